// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - digit-serial a+b+cin adder with sum, carry-out, group propagate and generate
module digit_serial_adder #(
    parameter int n = 16,
    parameter int k = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cin,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         prop,
    output logic         gen
);

    localparam int D  = n / k;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [n-1:0]  a_sh;
    logic [n-1:0]  b_sh;
    logic [n-1:0]  sum_sh;
    logic          c1;
    logic          c0;
    logic          p;
    logic [CW-1:0] cnt;

    logic [k-1:0]  ad;
    logic [k-1:0]  bd;
    logic [k:0]    dsum1;
    logic [k:0]    dsum0;
    logic [n-1:0]  sum_next;
    logic          p_next;

    assign ad     = a_sh[k-1:0];
    assign bd     = b_sh[k-1:0];
    assign dsum1  = {1'b0, ad} + {1'b0, bd} + {{k{1'b0}}, c1};
    assign dsum0  = {1'b0, ad} + {1'b0, bd} + {{k{1'b0}}, c0};
    assign p_next = p & (&(ad ^ bd));
    // New digit enters at the MSB end; the widened shift also covers k == n.
    assign sum_next = n'({dsum1[k-1:0], sum_sh} >> k);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            c1     <= 1'b0;
            c0     <= 1'b0;
            p      <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            cout   <= 1'b0;
            prop   <= 1'b0;
            gen    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        sum_sh <= '0;
                        c1     <= cin;
                        c0     <= 1'b0;
                        p      <= 1'b1;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> k;
                    b_sh   <= b_sh >> k;
                    sum_sh <= sum_next;
                    c1     <= dsum1[k];
                    c0     <= dsum0[k];
                    p      <= p_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s     <= sum_next;
                        cout  <= dsum1[k];
                        gen   <= dsum0[k];
                        prop  <= p_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - directed, back-to-back, reset-abort and parameter-sweep checks
module tb_digit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int sw_count = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic sweep_finished();
        sw_count++;
    endtask

    logic        m_rst, m_start, m_cin, m_busy, m_done, m_cout, m_prop, m_gen;
    logic [15:0] m_a, m_b, m_s;

    digit_serial_adder #(.n(16), .k(4)) dut (
        .clk(clk), .rst(m_rst), .start(m_start), .cin(m_cin), .a(m_a), .b(m_b),
        .busy(m_busy), .done(m_done), .s(m_s), .cout(m_cout), .prop(m_prop), .gen(m_gen)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        prop;
        logic        gen;
    } vec_t;

    vec_t vecs [7];

    // Runs one operation; lat counts edges from the accepting edge to the one that raises done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        m_a = a; m_b = b; m_cin = cin; m_start = 1'b1;
        @(posedge clk); #1;
        m_start = 1'b0;
        lat = 1;
        busy_cycles = m_busy ? 1 : 0;
        while (!m_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!m_done && m_busy) busy_cycles++;
        end
    endtask

    initial begin
        int lat, bc, seen_done;
        logic [15:0] va [20];
        logic [15:0] vb [20];
        logic        vc [20];
        logic [16:0] full;
        logic [15:0] prev_s;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h00FF, 16'hFF00, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0};

        m_rst = 1'b1; m_start = 1'b0; m_cin = 1'b0; m_a = '0; m_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {m_busy, m_done, m_s, m_cout, m_prop, m_gen}, 64'h0);
        @(negedge clk);
        m_rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bc);
            chk("vec_s", m_s, vecs[i].s);
            chk("vec_flags", {m_cout, m_prop, m_gen}, {vecs[i].cout, vecs[i].prop, vecs[i].gen});
            chk("vec_latency", lat, 5);
            chk("vec_busy_cycles", bc, 4);
            @(posedge clk); #1;
            chk("vec_done_one_cycle", m_done, 1'b0);
        end

        // start held high with operands changing each cycle
        prev_s = vecs[6].s;
        @(negedge clk);
        m_start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            va[c] = 16'($urandom); vb[c] = 16'($urandom); vc[c] = 1'($urandom);
            m_a = va[c]; m_b = vb[c]; m_cin = vc[c];
            @(posedge clk); #1;
            if (c % 5 == 4) begin
                full = {1'b0, va[c-4]} + {1'b0, vb[c-4]} + 17'(vc[c-4]);
                chk("b2b_done", m_done, 1'b1);
                chk("b2b_result", {m_cout, m_s}, full);
                prev_s = full[15:0];
            end else begin
                chk("b2b_idle_done", m_done, 1'b0);
                chk("b2b_hold_s", m_s, prev_s);
            end
            @(negedge clk);
        end
        m_start = 1'b0;
        repeat (2) @(posedge clk);

        // asynchronous reset two cycles into an operation
        run_op(16'h1111, 16'h2222, 1'b0, lat, bc);
        chk("pre_reset_s", m_s, 16'h3333);
        @(negedge clk);
        m_a = 16'hFFFF; m_b = 16'h0001; m_cin = 1'b0; m_start = 1'b1;
        @(posedge clk); #1;
        m_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 m_rst = 1'b1;
        #1;
        chk("abort_outputs", {m_busy, m_done, m_s, m_cout, m_prop, m_gen}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        m_rst = 1'b0;
        seen_done = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m_done) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_s_zero", m_s, 16'h0);
        run_op(16'h0F0F, 16'h00F1, 1'b1, lat, bc);
        chk("post_abort_s", m_s, 16'h1001);
        chk("post_abort_flags", {m_cout, m_prop, m_gen}, 3'b000);
        chk("post_abort_latency", lat, 5);

        while (sw_count < 3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int N = (g == 0) ? 8 : (g == 1) ? 16 : 32;
        localparam int K = (g == 0) ? 1 : (g == 1) ? 16 : 8;
        localparam int D = N / K;

        logic         rst, start, cin, busy, done, cout, prop, gen;
        logic [N-1:0] a, b, s;
        logic [N:0]   full, half;
        int           lat;

        digit_serial_adder #(.n(N), .k(K)) dut (
            .clk(clk), .rst(rst), .start(start), .cin(cin), .a(a), .b(b),
            .busy(busy), .done(done), .s(s), .cout(cout), .prop(prop), .gen(gen)
        );

        initial begin
            rst = 1'b1; start = 1'b0; cin = 1'b0; a = '0; b = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
                if (i % 16 == 0) begin
                    a = '1;
                    b = N'(i / 16 % 2);
                end
                full = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
                half = {1'b0, a} + {1'b0, b};
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                lat = 1;
                while (!done && lat < 100) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk("sweep_s", 64'(s), 64'(full[N-1:0]));
                chk("sweep_flags", {cout, prop, gen}, {full[N], &(a ^ b), half[N]});
                chk("sweep_latency", lat, D + 1);
            end
            sweep_finished();
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
